// File: rtl/octal_pkg.sv
// Shared constants and FSM state type for the serial octal subtractor.
package octal_pkg;
    localparam int DIGIT_W = 3;
    localparam int RADIX   = 8;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        FIX,
        DONE
    } state_t;
endpackage

// File: rtl/octal_digit_sub.sv
// Single radix-8 digit subtractor: diff = (x - y - bi) mod 8, bo = (x - y - bi < 0).
module octal_digit_sub
    import octal_pkg::*;
(
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    input  logic               bi,
    output logic [DIGIT_W-1:0] diff,
    output logic               bo
);
    logic [DIGIT_W:0] w_t;

    // Range is -8..7, so the extra bit doubles as the borrow.
    assign w_t  = {1'b0, x} - {1'b0, y} - {{DIGIT_W{1'b0}}, bi};
    assign diff = w_t[DIGIT_W-1:0];
    assign bo   = w_t[DIGIT_W];
endmodule

// File: rtl/octal_serial_sub.sv
// Digit-serial octal subtractor, LSD first; define OCTAL_SUB_ABS_EN to add a
// FIX pass that turns a negative wrapped result into its magnitude.
module octal_serial_sub
    import octal_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [3*DIGITS-1:0]     a,
    input  logic [3*DIGITS-1:0]     b,
    input  logic                    bin,
    output logic                    busy,
    output logic                    done,
    output logic [3*DIGITS-1:0]     d,
    output logic                    bout,
    output logic                    neg
);
    localparam int W  = DIGIT_W * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t               r_state;
    logic [W-1:0]         r_a;
    logic [W-1:0]         r_b;
    logic [W-1:0]         r_d;
    logic [IW-1:0]        r_idx;
    logic                 r_br;
    logic                 r_bout;
    logic                 r_neg;
    logic                 r_done;

    logic [DIGIT_W-1:0]   w_x;
    logic [DIGIT_W-1:0]   w_y;
    logic [DIGIT_W-1:0]   w_diff;
    logic                 w_bo;
    logic                 w_last;

    assign w_last = (r_idx == IW'(DIGITS - 1));

`ifdef OCTAL_SUB_ABS_EN
    // FIX negates the stored result digit by digit: 0 - d.
    assign w_x = (r_state == FIX) ? '0 : r_a[r_idx*DIGIT_W +: DIGIT_W];
    assign w_y = (r_state == FIX) ? r_d[r_idx*DIGIT_W +: DIGIT_W]
                                  : r_b[r_idx*DIGIT_W +: DIGIT_W];
`else
    assign w_x = r_a[r_idx*DIGIT_W +: DIGIT_W];
    assign w_y = r_b[r_idx*DIGIT_W +: DIGIT_W];
`endif

    octal_digit_sub u_digit (
        .x    (w_x),
        .y    (w_y),
        .bi   (r_br),
        .diff (w_diff),
        .bo   (w_bo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_d     <= '0;
            r_idx   <= '0;
            r_br    <= 1'b0;
            r_bout  <= 1'b0;
            r_neg   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= bin;
                        r_idx   <= '0;
                        r_state <= SUB;
                    end
                end
                SUB: begin
                    r_d[r_idx*DIGIT_W +: DIGIT_W] <= w_diff;
                    r_br <= w_bo;
                    if (w_last) begin
                        r_bout <= w_bo;
                        r_neg  <= w_bo;
                        r_idx  <= '0;
                        r_br   <= 1'b0;
`ifdef OCTAL_SUB_ABS_EN
                        r_state <= w_bo ? FIX : DONE;
`else
                        r_state <= DONE;
`endif
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
`ifdef OCTAL_SUB_ABS_EN
                FIX: begin
                    r_d[r_idx*DIGIT_W +: DIGIT_W] <= w_diff;
                    r_br <= w_bo;
                    if (w_last) begin
                        r_idx   <= '0;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
`endif
                DONE: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign d    = r_d;
    assign bout = r_bout;
    assign neg  = r_neg;
endmodule

// File: tb/tb_octal_serial_sub.sv
// Directed self-checking bench for octal_serial_sub (DIGITS=4); expected
// values follow OCTAL_SUB_ABS_EN when it is defined.
module tb_octal_serial_sub;
    localparam int DIGITS = 4;
    localparam int W      = 3 * DIGITS;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;
    logic         neg;

    int n_chk;
    int n_fail;

    octal_serial_sub #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout),
        .neg   (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag,
                          input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tbin, input logic [W-1:0] ed,
                          input logic eb, input logic en, input int elat);
        int lat;
        lat = 0;
        @(negedge clk);
        a     = ta;
        b     = tb;
        bin   = tbin;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        check({tag, " lat"}, lat, elat);
        check({tag, " d"}, d, ed);
        check({tag, " bout"}, bout, eb);
        check({tag, " neg"}, neg, en);
        check({tag, " busy"}, busy, 0);
        @(posedge clk);
        #1;
        check({tag, " pulse"}, done, 0);
        check({tag, " hold"}, d, ed);
    endtask

    initial begin
        int dones;
        logic [W-1:0] dsave;
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        bin    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst d", d, 0);
        check("rst bout", bout, 0);
        check("rst neg", neg, 0);
        rst_n = 1'b1;

        run_op("basic", 12'o7654, 12'o1234, 1'b0, 12'o6420, 1'b0, 1'b0, 5);
        run_op("ripple", 12'o1000, 12'o0001, 1'b0, 12'o0777, 1'b0, 1'b0, 5);
`ifdef OCTAL_SUB_ABS_EN
        run_op("neg1", 12'o0000, 12'o0001, 1'b0, 12'o0001, 1'b1, 1'b1, 9);
`else
        run_op("neg1", 12'o0000, 12'o0001, 1'b0, 12'o7777, 1'b1, 1'b1, 5);
`endif
        run_op("bin", 12'o0005, 12'o0004, 1'b1, 12'o0000, 1'b0, 1'b0, 5);
`ifdef OCTAL_SUB_ABS_EN
        run_op("ovf", 12'o0000, 12'o7777, 1'b1, 12'o0000, 1'b1, 1'b1, 9);
`else
        run_op("ovf", 12'o0000, 12'o7777, 1'b1, 12'o0000, 1'b1, 1'b1, 5);
`endif

        // start held high throughout the busy window with changing operands
        dones = 0;
        dsave = '0;
        @(negedge clk);
        a     = 12'o7654;
        b     = 12'o1234;
        bin   = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                dsave = d;
            end
            a     = 12'o0000;
            b     = 12'o7777;
            bin   = 1'b1;
            start = busy;
        end
        start = 1'b0;
        check("spam dones", dones, 1);
        check("spam d", dsave, 12'o6420);

        // reset during the second SUB cycle
        @(negedge clk);
        a     = 12'o7654;
        b     = 12'o1234;
        bin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort d", d, 0);
        check("abort bout", bout, 0);
        check("abort neg", neg, 0);
        #1 rst_n = 1'b1;
        run_op("post", 12'o7654, 12'o1234, 1'b0, 12'o6420, 1'b0, 1'b0, 5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
